// File: rtl/nlc_input_buffer.sv
// Sample FIFO feeding the NLC engine one sample at a time; issue strobe follows a non-empty FIFO by one edge.
// No backpressure to the ADC: samples arriving at a full FIFO are dropped and counted; a watchdog frees a hung engine.
module nlc_input_buffer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              srdyi,
  input  logic [20:0]       x_adc_in,
  output logic              nlc_srdyi,
  output logic [20:0]       nlc_x_adc,
  input  logic              nlc_srdyo,
  output logic              busy,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [15:0]       drop_count,
  input  logic              clear_ovf,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [ADDR_W:0]  L_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] L_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            r_state;
  logic [20:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_nlc_srdyi;
  logic [20:0]       r_nlc_x_adc;
  logic              r_busy;
  logic              r_overflow;
  logic [15:0]       r_drop_count;
  logic              r_timeout;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees a slot on the same edge, so a full FIFO can still accept a write then.
  assign w_full = (r_count == L_FULL);
  assign w_pop  = (r_state == IDLE) && (r_count != '0);
  assign w_push = srdyi && (!w_full || w_pop);
  assign w_drop = srdyi && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= x_adc_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop coinciding with a clear is kept as the first event after the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear_ovf) begin
      r_overflow   <= w_drop;
      r_drop_count <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_nlc_srdyi <= 1'b0;
      r_nlc_x_adc <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_nlc_srdyi <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state     <= ISSUE;
            r_nlc_srdyi <= 1'b1;
            r_nlc_x_adc <= r_mem[r_rd_ptr];
            r_busy      <= 1'b1;
          end
        end
        ISSUE: begin
          r_state    <= WAIT;
          r_wait_cnt <= '0;
        end
        WAIT: begin
          // Completion takes priority over the watchdog on the limit cycle.
          if (nlc_srdyo) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_wait_cnt == L_LIMIT) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign nlc_srdyi  = r_nlc_srdyi;
  assign nlc_x_adc  = r_nlc_x_adc;
  assign busy       = r_busy;
  assign fill_level = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_nlc_input_buffer.sv
// Directed bench for nlc_input_buffer: default instance for FIFO/issue behaviour, TIMEOUT=16 instance for the watchdog.
module tb_nlc_input_buffer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        srdyi, nlc_srdyo, clear_ovf;
  logic [20:0] x_adc_in;
  logic        nlc_srdyi, busy, overflow, timeout;
  logic [20:0] nlc_x_adc;
  logic [3:0]  fill_level;
  logic [15:0] drop_count;

  logic        b_srdyi, b_nlc_srdyo, b_clear_ovf;
  logic [20:0] b_x_adc_in;
  logic        b_nlc_srdyi, b_busy, b_overflow, b_timeout;
  logic [20:0] b_nlc_x_adc;
  logic [3:0]  b_fill_level;
  logic [15:0] b_drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nlc_input_buffer #(.DEPTH(8), .ADDR_W(3), .TIMEOUT(1024)) u_dut (
    .clk(clk), .reset(rst_n), .srdyi(srdyi), .x_adc_in(x_adc_in),
    .nlc_srdyi(nlc_srdyi), .nlc_x_adc(nlc_x_adc), .nlc_srdyo(nlc_srdyo),
    .busy(busy), .fill_level(fill_level), .overflow(overflow),
    .drop_count(drop_count), .clear_ovf(clear_ovf), .timeout(timeout)
  );

  nlc_input_buffer #(.DEPTH(8), .ADDR_W(3), .TIMEOUT(16)) u_dut_wd (
    .clk(clk), .reset(rst_n), .srdyi(b_srdyi), .x_adc_in(b_x_adc_in),
    .nlc_srdyi(b_nlc_srdyi), .nlc_x_adc(b_nlc_x_adc), .nlc_srdyo(b_nlc_srdyo),
    .busy(b_busy), .fill_level(b_fill_level), .overflow(b_overflow),
    .drop_count(b_drop_count), .clear_ovf(b_clear_ovf), .timeout(b_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({nlc_srdyi, busy, overflow, timeout, fill_level, drop_count, nlc_x_adc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got srdyi=%b busy=%b ovf=%b tmo=%b fill=%0d drops=%0d x=%h, required all 0",
               nlc_srdyi, busy, overflow, timeout, fill_level, drop_count, nlc_x_adc);
    end
    #19 rst_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, fill_level, b_busy, b_fill_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b fill=%0d b_busy=%b b_fill=%0d, required 0", busy, fill_level, b_busy, b_fill_level);
    end
  endtask

  task automatic test_single();
    int highs;
    srdyi = 1'b1; x_adc_in = 21'h000123;
    tick();
    srdyi = 1'b0;
    n_checks++;
    if (fill_level !== 4'd1 || nlc_srdyi !== 1'b0) begin
      n_fail++;
      $display("FAIL single_push: got fill=%0d srdyi=%b, required fill=1 srdyi=0", fill_level, nlc_srdyi);
    end
    tick();
    n_checks++;
    if (nlc_srdyi !== 1'b1 || nlc_x_adc !== 21'h000123 || busy !== 1'b1 || fill_level !== 4'd0) begin
      n_fail++;
      $display("FAIL single_issue: got srdyi=%b x=%h busy=%b fill=%0d, required 1 000123 1 0", nlc_srdyi, nlc_x_adc, busy, fill_level);
    end
    highs = 0;
    for (int i = 0; i < 38; i++) begin
      tick();
      if (nlc_srdyi) highs++;
    end
    n_checks++;
    if (highs !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_strobe_width: got extra_highs=%0d busy=%b, required 0 and busy=1", highs, busy);
    end
    nlc_srdyo = 1'b1;
    tick();
    nlc_srdyo = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || fill_level !== 4'd0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_complete: got busy=%b fill=%0d tmo=%b, required 0 0 0", busy, fill_level, timeout);
    end
  endtask

  task automatic test_burst();
    int eng_cnt, n_iss, peak;
    logic done_seen;
    logic [20:0] order [5];
    eng_cnt = 0; n_iss = 0; peak = 0; done_seen = 1'b1;
    for (int k = 0; k < 5; k++) order[k] = '0;
    for (int i = 0; i < 400; i++) begin
      srdyi     = (i < 5);
      x_adc_in  = 21'(i + 1);
      nlc_srdyo = (eng_cnt == 1);
      tick();
      if (nlc_srdyo) done_seen = 1'b1;
      if (int'(fill_level) > peak) peak = int'(fill_level);
      if (nlc_srdyi) begin
        n_checks++;
        if (!done_seen || n_iss >= 5) begin
          n_fail++;
          $display("FAIL burst_spacing: issue %0d with completion_seen=%b, required completion before each issue", n_iss, done_seen);
        end
        if (n_iss < 5) order[n_iss] = nlc_x_adc;
        n_iss++;
        done_seen = 1'b0;
        eng_cnt = 20;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
      end
      if (i >= 5 && n_iss == 5 && !busy) break;
    end
    srdyi = 1'b0; nlc_srdyo = 1'b0;
    n_checks++;
    if (n_iss !== 5) begin
      n_fail++;
      $display("FAIL burst_count: got %0d issues, required 5", n_iss);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (order[k] !== 21'(k + 1)) begin
        n_fail++;
        $display("FAIL burst_order[%0d]: got %h, required %h", k, order[k], 21'(k + 1));
      end
    end
    n_checks++;
    if (peak !== 4 || fill_level !== 4'd0) begin
      n_fail++;
      $display("FAIL burst_fill: got peak=%0d final=%0d, required peak=4 final=0", peak, fill_level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) begin
      srdyi = 1'b1; x_adc_in = 21'(32'h100 + i);
      tick();
    end
    srdyi = 1'b0;
    n_checks++;
    if (fill_level !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd3 || nlc_x_adc !== 21'h100) begin
      n_fail++;
      $display("FAIL overflow_drop: got fill=%0d ovf=%b drops=%0d x=%h, required 8 1 3 100", fill_level, overflow, drop_count, nlc_x_adc);
    end
    srdyi = 1'b1; clear_ovf = 1'b1; x_adc_in = 21'h1FF;
    tick();
    srdyi = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd1) begin
      n_fail++;
      $display("FAIL overflow_clear_and_drop: got ovf=%b drops=%0d, required 1 1", overflow, drop_count);
    end
    tick();
    clear_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || drop_count !== 16'd0 || fill_level !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow_clear: got ovf=%b drops=%0d fill=%0d, required 0 0 8", overflow, drop_count, fill_level);
    end
  endtask

  task automatic test_full_pop();
    logic [20:0] exp_x;
    nlc_srdyo = 1'b1;
    tick();
    nlc_srdyo = 1'b0;
    srdyi = 1'b1; x_adc_in = 21'h1AB;
    tick();
    srdyi = 1'b0;
    n_checks++;
    if (fill_level !== 4'd8 || overflow !== 1'b0 || drop_count !== 16'd0 || nlc_srdyi !== 1'b1 || nlc_x_adc !== 21'h101) begin
      n_fail++;
      $display("FAIL full_pop_push: got fill=%0d ovf=%b drops=%0d srdyi=%b x=%h, required 8 0 0 1 101",
               fill_level, overflow, drop_count, nlc_srdyi, nlc_x_adc);
    end
    for (int k = 0; k < 8; k++) begin
      exp_x = (k < 7) ? 21'(32'h102 + k) : 21'h1AB;
      tick();
      nlc_srdyo = 1'b1;
      tick();
      nlc_srdyo = 1'b0;
      tick();
      n_checks++;
      if (nlc_srdyi !== 1'b1 || nlc_x_adc !== exp_x) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got srdyi=%b x=%h, required 1 %h", k, nlc_srdyi, nlc_x_adc, exp_x);
      end
    end
    tick();
    nlc_srdyo = 1'b1;
    tick();
    nlc_srdyo = 1'b0;
    n_checks++;
    if (fill_level !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: got fill=%0d busy=%b, required 0 0", fill_level, busy);
    end
  endtask

  task automatic test_watchdog();
    int pulses;
    b_srdyi = 1'b1; b_x_adc_in = 21'h0000AA;
    tick();
    b_x_adc_in = 21'h0000BB;
    tick();
    b_srdyi = 1'b0;
    n_checks++;
    if (b_nlc_srdyi !== 1'b1 || b_nlc_x_adc !== 21'h0000AA) begin
      n_fail++;
      $display("FAIL wd_first_issue: got srdyi=%b x=%h, required 1 0000aa", b_nlc_srdyi, b_nlc_x_adc);
    end
    tick();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (b_timeout) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || b_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_early: got pulses=%0d busy=%b before limit, required 0 1", pulses, b_busy);
    end
    tick();
    n_checks++;
    if (b_timeout !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_fire: got tmo=%b busy=%b at WAIT+16, required 1 0", b_timeout, b_busy);
    end
    tick();
    n_checks++;
    if (b_timeout !== 1'b0 || b_nlc_srdyi !== 1'b1 || b_nlc_x_adc !== 21'h0000BB) begin
      n_fail++;
      $display("FAIL wd_next_issue: got tmo=%b srdyi=%b x=%h, required 0 1 0000bb", b_timeout, b_nlc_srdyi, b_nlc_x_adc);
    end
    tick();
    for (int i = 0; i < 15; i++) tick();
    b_nlc_srdyo = 1'b1;
    tick();
    b_nlc_srdyo = 1'b0;
    n_checks++;
    if (b_timeout !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_complete_on_limit: got tmo=%b busy=%b, required 0 0", b_timeout, b_busy);
    end
    tick();
    n_checks++;
    if (b_timeout !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_after_complete: got tmo=%b busy=%b, required 0 0", b_timeout, b_busy);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      srdyi = 1'b1; x_adc_in = 21'(32'h200 + i);
      tick();
    end
    srdyi = 1'b0;
    n_checks++;
    if (fill_level !== 4'd3 || busy !== 1'b1 || nlc_x_adc !== 21'h200) begin
      n_fail++;
      $display("FAIL areset_setup: got fill=%0d busy=%b x=%h, required 3 1 200", fill_level, busy, nlc_x_adc);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({nlc_srdyi, busy, overflow, timeout, fill_level, drop_count, nlc_x_adc} !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: got srdyi=%b busy=%b ovf=%b tmo=%b fill=%0d drops=%0d x=%h, required all 0",
               nlc_srdyi, busy, overflow, timeout, fill_level, drop_count, nlc_x_adc);
    end
    n_checks++;
    if ({b_busy, b_fill_level, b_nlc_x_adc} !== '0) begin
      n_fail++;
      $display("FAIL areset_wd_inst: got busy=%b fill=%0d x=%h, required 0", b_busy, b_fill_level, b_nlc_x_adc);
    end
    #2 rst_n = 1'b1;
    tick();
    nlc_srdyo = 1'b1;
    tick();
    nlc_srdyo = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || fill_level !== 4'd0 || nlc_srdyi !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_stray: got busy=%b fill=%0d srdyi=%b tmo=%b, required 0 0 0 0", busy, fill_level, nlc_srdyi, timeout);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || nlc_srdyi !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: got busy=%b srdyi=%b, required 0 0", busy, nlc_srdyi);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    srdyi = 1'b0; nlc_srdyo = 1'b0; clear_ovf = 1'b0; x_adc_in = '0;
    b_srdyi = 1'b0; b_nlc_srdyo = 1'b0; b_clear_ovf = 1'b0; b_x_adc_in = '0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_watchdog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nlc_input_buffer.md
# nlc_input_buffer

Sample buffer and issue sequencer directly upstream of the 1-channel ADC non-linearity correction engine. Accepts 21-bit ADC samples at any rate and stores them in a FIFO. Issues them one at a time to the engine, waiting for the engine's completion strobe before issuing the next. Tracks overflow drops and recovers from a hung engine with a watchdog timeout.

## Interface
Parameters:
- DEPTH, 8, FIFO depth in samples; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- TIMEOUT, 1024, maximum number of WAIT-state cycles before the engine is declared hung; at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- srdyi  input  1  ADC sample valid; one sample per cycle when high.
- x_adc_in  input  21  ADC sample, two's complement.
- nlc_srdyi  output  1  one-cycle issue strobe to the engine's srdyi.
- nlc_x_adc  output  21  sample presented to the engine's x_adc; held stable between issues.
- nlc_srdyo  input  1  engine completion strobe (the engine's srdyo).
- busy  output  1  high when state != IDLE.
- fill_level  output  ADDR_W+1  number of samples currently in the FIFO, 0..DEPTH.
- overflow  output  1  sticky flag; set when a sample is dropped.
- drop_count  output  16  number of dropped samples; saturates at 16'hFFFF.
- clear_ovf  input  1  synchronous clear of overflow and drop_count.
- timeout  output  1  one-cycle pulse when the watchdog fires.

## Operation
- Reset (reset=0, asynchronous) sets the following, regardless of the clock:
  - state=IDLE; FIFO pointers 0; fill_level=0.
  - nlc_srdyi=0, nlc_x_adc=0, overflow=0, drop_count=0, timeout=0, busy=0.
  - Wait counter 0.
- All outputs are registered.
- FIFO behaviour:
  - Write when srdyi=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle. In that case the write is accepted and fill_level is unchanged.
  - Write attempted while full with no pop: the sample is dropped, overflow is set, and drop_count increments (saturating).
  - clear_ovf=1 zeroes overflow and drop_count. If a drop happens in the same cycle, the result is overflow=1 and drop_count=1.
- State machine, one transition per cycle at most:
  - IDLE: if fill_level>0, go to ISSUE. On this edge, pop the head into nlc_x_adc. Otherwise stay in IDLE.
  - ISSUE: nlc_srdyi=1 for this single cycle. Clear the wait counter and go to WAIT. nlc_srdyo is ignored here.
  - WAIT: nlc_srdyi=0. If nlc_srdyo=1, go to IDLE. Otherwise, if the wait counter equals TIMEOUT-1, pulse timeout for one cycle and go to IDLE. Otherwise increment the wait counter.
  - If nlc_srdyo=1 and the watchdog limit are reached in the same cycle, completion wins and timeout is not pulsed.
- nlc_srdyo while in IDLE is ignored (stray strobe); it has no effect on state or counters.
- A sample dropped on timeout is not retried. Its successor is issued normally.
- nlc_x_adc changes only on an IDLE→ISSUE transition.
- FIFO ordering is strict first-in-first-out. Pointers wrap modulo DEPTH.

## Timing
- Issue latency: a sample written at edge E into an empty FIFO with state=IDLE gives IDLE→ISSUE at edge E+1. nlc_srdyi is high from E+1 to E+2, and nlc_x_adc is valid from E+1.
- Back-to-back issues: nlc_srdyo sampled at edge C gives IDLE at C, ISSUE at C+1 if the FIFO is non-empty. The minimum issue spacing is therefore 3 cycles plus the engine latency.
- fill_level reflects pushes and pops of the previous edge. A pop happens on the same edge as IDLE→ISSUE.
- Watchdog: entering WAIT at edge W with no completion gives a timeout pulse and IDLE at edge W+TIMEOUT.
- Reset mid-operation: all state clears immediately. An in-flight engine result arriving after reset deasserts is a stray strobe and is ignored.

## Test plan
- Single sample: reset, then srdyi=1 with x_adc_in=21'h000123 for one cycle. Required: nlc_srdyi high exactly 1 cycle, starting 1 edge later, with nlc_x_adc=21'h000123. Return nlc_srdyo after 40 cycles; busy falls at that edge and fill_level=0.
- Burst ordering: push 5 samples 1..5 on consecutive cycles while the engine takes 20 cycles each. Required: issues occur in order 1..5, each after the previous nlc_srdyo, and fill_level peaks at 4.
- Overflow: DEPTH=8 with the engine stalled; push 12 samples. Required: 9 accepted (8 in the FIFO plus 1 already issued), overflow=1, drop_count=3. Assert clear_ovf together with one more drop: overflow=1, drop_count=1.
- Full plus pop: FIFO full, nlc_srdyo arrives, then a push in the same cycle as the IDLE→ISSUE pop. Required: no drop and fill_level stays 8.
- Watchdog: TIMEOUT=16 and never return nlc_srdyo. Required: timeout pulses 16 edges after entering WAIT and the next queued sample issues 1 edge later. Also check that completion on the limit cycle gives no timeout pulse.
- Async reset: assert reset=0 mid-WAIT with 3 samples queued, off the clock edge. Required: all outputs 0 immediately. After release, a stray nlc_srdyo is ignored and busy=0.
